// File: rtl/bit_serial_adder.sv
// Sequential LSB-first adder: a single full-adder slice, built from two half
// adders and an OR gate, consumes one operand bit pair per clock.

module half_adder (
    input  logic a_i,
    input  logic b_i,
    output logic sum_o,
    output logic carry_o
);
    assign sum_o   = a_i ^ b_i;
    assign carry_o = a_i & b_i;
endmodule

module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_a_q, sr_a_d;
    logic [WIDTH-1:0] sr_b_q, sr_b_d;
    // Partial sum holds only the WIDTH-1 bits gathered before the final bit;
    // the last bit goes straight from the adder slice into the result.
    logic [WIDTH-2:0] sr_s_q, sr_s_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic half_sum, gen0, bit_sum, gen1, bit_carry, last_bit;

    half_adder u_ha0 (
        .a_i     (sr_a_q[0]),
        .b_i     (sr_b_q[0]),
        .sum_o   (half_sum),
        .carry_o (gen0)
    );

    half_adder u_ha1 (
        .a_i     (half_sum),
        .b_i     (carry_q),
        .sum_o   (bit_sum),
        .carry_o (gen1)
    );

    assign bit_carry = gen0 | gen1;
    assign last_bit  = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        // NOTE: every next-state signal takes its held value first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        state_d = state_q;
        sr_a_d  = sr_a_q;
        sr_b_d  = sr_b_q;
        sr_s_d  = sr_s_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    sr_a_d  = i_a;
                    sr_b_d  = i_b;
                    carry_d = i_cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sr_a_d  = sr_a_q >> 1;
                sr_b_d  = sr_b_q >> 1;
                sr_s_d  = (WIDTH-1)'({bit_sum, sr_s_q} >> 1);
                carry_d = bit_carry;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    sum_d   = {bit_sum, sr_s_q};
                    cout_d  = bit_carry;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // NOTE: the whole datapath is cleared, not just the FSM, so no
            // stale operand bits survive a reset taken mid-operation.
            state_q <= IDLE;
            sr_a_q  <= '0;
            sr_b_q  <= '0;
            sr_s_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_a_q  <= sr_a_d;
            sr_b_q  <= sr_b_d;
            sr_s_q  <= sr_s_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_busy = (state_q != IDLE);
    assign o_done = (state_q == DONE);
    assign o_sum  = sum_q;
    assign o_cout = cout_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder (WIDTH=8): directed vectors,
// multi-cycle corner sequences and random operands against an arithmetic model.

module tb_bit_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         cin;
    logic         busy, done, cout;
    logic [W-1:0] sum;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bit_serial_adder #(.WIDTH(W)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (start),
        .i_a     (a),
        .i_b     (b),
        .i_cin   (cin),
        .o_busy  (busy),
        .o_done  (done),
        .o_sum   (sum),
        .o_cout  (cout)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Arithmetic reference: {cout,sum} = a + b + cin modulo 2^(W+1).
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    // Issues one addition from IDLE and waits for o_done. lat is the number of
    // falling edges after the start edge at which o_done is first seen.
    task automatic run_add(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                           output logic [W-1:0] rs, output logic rc, output int lat);
        @(negedge clk);
        a = xa; b = xb; cin = xc; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("done_seen", {31'd0, done}, 32'd1);
        rs = sum;
        rc = cout;
    endtask

    vec_t         vecs[5];
    logic [W-1:0] rs;
    logic         rc;
    logic [W:0]   exp;
    int           lat;
    int           n_done;
    logic [W:0]   expq[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};

        // Reset, with start asserted alongside it: reset must win.
        rst = 1'b1; start = 1'b1; a = 8'hA5; b = 8'h5A; cin = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sum", {24'd0, sum}, 32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("post_rst_idle", {31'd0, busy}, 32'd0);

        // Directed vectors.
        for (int i = 0; i < 5; i++) begin
            run_add(vecs[i].a, vecs[i].b, vecs[i].cin, rs, rc, lat);
            check($sformatf("vec%0d_sum", i), {24'd0, rs}, {24'd0, vecs[i].exp_sum});
            check($sformatf("vec%0d_cout", i), {31'd0, rc}, {31'd0, vecs[i].exp_cout});
            check($sformatf("vec%0d_latency", i), lat, 32'd9);
        end

        // Start pulsed during RUN is ignored; operands change after capture.
        @(negedge clk);
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n_done = 0;
        for (int n = 2; n <= 30; n++) begin
            @(negedge clk);
            if (n == 3) begin
                a = 8'h01; b = 8'h01; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                n_done++;
                check("ignore_sum", {24'd0, sum}, 32'h30);
                check("ignore_cout", {31'd0, cout}, 32'd0);
            end
        end
        check("ignore_single_done", n_done, 32'd1);
        check("ignore_sum_held", {24'd0, sum}, 32'h30);

        // Reset in the 4th RUN cycle abandons the operation.
        @(negedge clk);
        a = 8'hAA; b = 8'h55; cin = 1'b1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("run_busy", {31'd0, busy}, 32'd1);
        check("run_sum_stable", {24'd0, sum}, 32'h30);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_sum", {24'd0, sum}, 32'd0);
        check("midrst_cout", {31'd0, cout}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        n_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("midrst_no_done", n_done, 32'd0);
        run_add(8'h0F, 8'h01, 1'b0, rs, rc, lat);
        check("after_rst_sum", {24'd0, rs}, 32'h10);
        check("after_rst_cout", {31'd0, rc}, 32'd0);

        // Random single operations against the model.
        for (int i = 0; i < 16; i++) begin
            logic [W-1:0] ra, rb;
            logic         rcin;
            ra = W'($urandom); rb = W'($urandom); rcin = 1'($urandom);
            exp = model(ra, rb, rcin);
            run_add(ra, rb, rcin, rs, rc, lat);
            check($sformatf("rand%0d_result", i), {23'd0, rc, rs}, {23'd0, exp});
        end

        // Start held high: one result every WIDTH+2 cycles.
        @(negedge clk);
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); start = 1'b1;
        expq.push_back(model(a, b, cin));
        n_done = 0;
        begin
            int last_n;
            last_n = -1;
            for (int n = 0; n < 400 && n_done < 20; n++) begin
                @(negedge clk);
                if (done) begin
                    n_done++;
                    if (expq.size() > 0) begin
                        exp = expq.pop_front();
                        check("stream_result", {23'd0, cout, sum}, {23'd0, exp});
                    end
                    if (last_n >= 0) check("stream_period", n - last_n, 32'd10);
                    last_n = n;
                    if (n_done < 20) begin
                        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
                        expq.push_back(model(a, b, cin));
                    end else begin
                        start = 1'b0;
                    end
                end
            end
        end
        start = 1'b0;
        check("stream_count", n_done, 32'd20);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
